// File: rtl/led_matrix_pkg.sv
// Shared constants, frame-word layout and FSM encoding for the LED matrix
// frame buffer and its HUB75 scan driver.
package led_matrix_pkg;

  localparam int COLS      = 96;
  localparam int ROW_PAIRS = 24;
  localparam int ADDR_W    = 12;
  localparam int CH_W      = 4;
  localparam int MAX_LEVEL = 6;

  localparam int PIX_W  = 3 * CH_W;
  localparam int WORD_W = 2 * PIX_W;

  // Field offsets inside one 24-bit frame word
  localparam int R_UP = 20;
  localparam int G_UP = 16;
  localparam int B_UP = 12;
  localparam int R_LO = 8;
  localparam int G_LO = 4;
  localparam int B_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_CLEAR
  } fbw_state_t;

  function automatic logic [CH_W-1:0] clamp_channel(input logic [CH_W-1:0] c);
    return (c > CH_W'(MAX_LEVEL)) ? CH_W'(MAX_LEVEL) : c;
  endfunction

endpackage

// File: rtl/pixel_clamp.sv
// Limits each RGB444 channel to the highest level the scan driver's PWM can show.
module pixel_clamp
  import led_matrix_pkg::*;
(
  input  logic [PIX_W-1:0] pixel,
  output logic [PIX_W-1:0] clamped
);

  always_comb begin
    clamped = '0;
    clamped[R_LO +: CH_W] = clamp_channel(pixel[R_LO +: CH_W]);
    clamped[G_LO +: CH_W] = clamp_channel(pixel[G_LO +: CH_W]);
    clamped[B_LO +: CH_W] = clamp_channel(pixel[B_LO +: CH_W]);
  end

endmodule

// File: rtl/frame_buffer_writer.sv
// Packs a raster-order RGB444 pixel stream into the shared frame RAM using
// read-modify-write so the other half of each word is preserved.
module frame_buffer_writer
  import led_matrix_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [PIX_W-1:0]  i_pixel,
  input  logic              i_sof,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_clear,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_stb,
  input  logic [WORD_W-1:0] i_rd_data,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_wr_en,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic              o_clear_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROW_PAIRS - 1);

  fbw_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic              half;
  logic [PIX_W-1:0]  pixel_q;
  logic [PIX_W-1:0]  pixel_clamped;

  pixel_clamp u_pixel_clamp (
    .pixel   (i_pixel),
    .clamped (pixel_clamped)
  );

  assign o_ready = i_rst && (state == ST_IDLE) && !i_clear;

  // half=0 selects the upper word half (rows 0..23), half=1 the lower half
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= ST_IDLE;
      addr         <= '0;
      half         <= 1'b0;
      pixel_q      <= '0;
      o_rd_addr    <= '0;
      o_rd_stb     <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_clear_done <= 1'b0;
    end else begin
      o_rd_stb     <= 1'b0;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_clear) begin
            state     <= ST_CLEAR;
            o_wr_en   <= 1'b1;
            o_wr_addr <= '0;
            o_wr_data <= '0;
          end else if (i_valid) begin
            pixel_q  <= pixel_clamped;
            o_rd_stb <= 1'b1;
            state    <= ST_READ;
            if (i_sof) begin
              addr        <= '0;
              half        <= 1'b0;
              o_rd_addr   <= '0;
              o_frame_err <= (addr != '0) || half;
            end else begin
              o_rd_addr <= addr;
            end
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          o_wr_en   <= 1'b1;
          o_wr_addr <= addr;
          o_wr_data <= half ? {i_rd_data[WORD_W-1:B_UP], pixel_q}
                            : {pixel_q, i_rd_data[B_UP-1:0]};
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          if (addr == LAST_ADDR) begin
            addr         <= '0;
            half         <= ~half;
            o_frame_done <= half;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (o_wr_addr == LAST_ADDR) begin
            state        <= ST_IDLE;
            addr         <= '0;
            half         <= 1'b0;
            o_clear_done <= 1'b1;
          end else begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= o_wr_addr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
